// File: rtl/pe_result_writeback_pkg.sv
// rtl/pe_result_writeback_pkg.sv - shared constants and entry type for the PE result writeback stage
// Contents: geometry of the PE array, quantizer limits, and the FIFO entry
// struct {pool flag, all quantized pixels of one result}.
package pe_wb_pkg;
   localparam int X_PE        = 16;
   localparam int RESULT_SIZE = 2;
   localparam int NPIX        = RESULT_SIZE * RESULT_SIZE;
   localparam int OUT_BIT     = 24;
   localparam int Q_BIT       = 8;
   localparam int DEPTH       = 4;
   localparam int Q_MAX       = 127;
   localparam int Q_MIN       = -128;
   localparam int SHIFT_MAX   = 23;
   localparam int BEAT_W      = X_PE * Q_BIT;
   localparam int ENTRY_W     = NPIX * BEAT_W;

   // data holds beat p at bits [p*BEAT_W +: BEAT_W], lane i within a beat at [i*Q_BIT +: Q_BIT]
   typedef struct packed {
      logic               pool;
      logic [ENTRY_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/pe_result_writeback_if.sv
// rtl/pe_result_writeback_if.sv - output beat stream toward the feature-map buffer
// Signals: out_valid/out_data/out_last driven by the master, out_ready by the slave.
interface pe_result_writeback_if;
   import pe_wb_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [BEAT_W-1:0] out_data;
   logic              out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/pe_result_writeback_quant.sv
// rtl/pe_result_writeback_quant.sv - one-lane requantizer: ReLU, round-half-up shift, saturation
// Ports: v_i signed accumulator, shift_i right-shift (clamped to SHIFT_MAX),
// relu_en_i zero negatives, q_o signed Q_BIT result. Purely combinational.
module pe_wb_quant
   import pe_wb_pkg::*;
(
   input  logic [OUT_BIT-1:0] v_i,
   input  logic [4:0]         shift_i,
   input  logic               relu_en_i,
   output logic [Q_BIT-1:0]   q_o
);
   localparam logic signed [OUT_BIT:0] HI = (OUT_BIT+1)'(Q_MAX);
   localparam logic signed [OUT_BIT:0] LO = (OUT_BIT+1)'(Q_MIN);

   logic        [4:0]       sh;
   logic signed [OUT_BIT:0] ext_s;
   logic signed [OUT_BIT:0] rnd_s;
   logic signed [OUT_BIT:0] sum_s;
   logic signed [OUT_BIT:0] r_s;

   always_comb begin
      sh    = (shift_i > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : shift_i;
      ext_s = (relu_en_i && v_i[OUT_BIT-1]) ? '0 : {v_i[OUT_BIT-1], v_i};
      // One extra bit keeps the rounding add from wrapping at the positive extreme.
      rnd_s = (sh != 5'd0) ? ((OUT_BIT+1)'(1) << (sh - 5'd1)) : '0;
      sum_s = ext_s + rnd_s;
      r_s   = sum_s >>> sh;
      if (r_s > HI) begin
         q_o = HI[Q_BIT-1:0];
      end else if (r_s < LO) begin
         q_o = LO[Q_BIT-1:0];
      end else begin
         q_o = r_s[Q_BIT-1:0];
      end
   end
endmodule

// File: rtl/pe_result_writeback.sv
// rtl/pe_result_writeback.sv - requantize PE results, buffer them, and serialize into output beats
// Ports: clk/rst (sync, active-high); in_valid/poolop/shift/relu_en with
// result_unpool/result_pool from the PE core; out_s beat stream (master);
// almost_full (occupancy >= DEPTH-1) and sticky overflow (entry dropped).
module pe_result_writeback
   import pe_wb_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         poolop,
   input  logic [OUT_BIT*NPIX*X_PE-1:0] result_unpool,
   input  logic [OUT_BIT*X_PE-1:0]      result_pool,
   input  logic [4:0]                   shift,
   input  logic                         relu_en,
   pe_result_writeback_if.master        out_s,
   output logic                         almost_full,
   output logic                         overflow
);
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int BCNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [ENTRY_W-1:0] q_all;
   logic               q_valid_q;
   entry_t             q_entry_q;
   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [BCNT_W-1:0]  beat_q, beat_d;
   logic               overflow_q, overflow_d;
   entry_t             head;
   logic               head_valid, head_last, fire, pop, push;

   // Pixel-0 lanes double as the pooled lanes, so a pooled entry lands in beat slot 0.
   for (genvar i = 0; i < X_PE; i++) begin : g_pe
      for (genvar p = 0; p < NPIX; p++) begin : g_pix
         logic [OUT_BIT-1:0] v;
         assign v = (p == 0 && poolop) ? result_pool[i*OUT_BIT +: OUT_BIT]
                                       : result_unpool[(i*NPIX+p)*OUT_BIT +: OUT_BIT];
         pe_wb_quant u_quant (
            .v_i       (v),
            .shift_i   (shift),
            .relu_en_i (relu_en),
            .q_o       (q_all[(p*X_PE+i)*Q_BIT +: Q_BIT])
         );
      end
   end

   always_comb begin
      head       = mem_q[rd_ptr_q];
      head_valid = (count_q != '0);
      head_last  = head_valid && (head.pool || (beat_q == BCNT_W'(NPIX - 1)));
      fire       = head_valid && out_s.out_ready;
      pop        = fire && head_last;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push       = q_valid_q && ((count_q < CNT_W'(DEPTH)) || pop);

      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      beat_d = beat_q;
      if (pop) begin
         beat_d = '0;
      end else if (fire) begin
         beat_d = beat_q + 1'b1;
      end
      overflow_d = overflow_q || (q_valid_q && !push);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         beat_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         q_valid_q  <= in_valid;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         beat_q     <= beat_d;
         overflow_q <= overflow_d;
      end
   end

   // Payload registers carry no reset; out_valid gates everything visible.
   always_ff @(posedge clk) begin
      if (!rst && in_valid) begin
         q_entry_q.pool <= poolop;
         q_entry_q.data <= q_all;
      end
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= q_entry_q;
      end
   end

   assign out_s.out_valid = head_valid;
   assign out_s.out_last  = head_last;
   assign out_s.out_data  = head_valid ? head.data[beat_q*BEAT_W +: BEAT_W] : '0;
   assign almost_full     = (count_q >= CNT_W'(DEPTH - 1));
   assign overflow        = overflow_q;
endmodule

// File: tb/tb_pe_result_writeback.sv
// tb/tb_pe_result_writeback.sv - self-checking bench for pe_result_writeback
module tb_pe_result_writeback;
   import pe_wb_pkg::*;

   localparam int UN_W = OUT_BIT * NPIX * X_PE;
   localparam int PL_W = OUT_BIT * X_PE;

   typedef struct packed {
      logic                             pool;
      logic [4:0]                       sh;
      logic                             relu;
      logic [NPIX-1:0][OUT_BIT-1:0]     v;
      logic [NPIX-1:0][Q_BIT-1:0]       e;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              poolop;
   logic [UN_W-1:0]   result_unpool;
   logic [PL_W-1:0]   result_pool;
   logic [4:0]        shift;
   logic              relu_en;
   logic              almost_full;
   logic              overflow;

   pe_result_writeback_if wb_if ();

   pe_result_writeback dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .poolop        (poolop),
      .result_unpool (result_unpool),
      .result_pool   (result_pool),
      .shift         (shift),
      .relu_en       (relu_en),
      .out_s         (wb_if),
      .almost_full   (almost_full),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   vec_t               vecs [9];
   logic [UN_W-1:0]    un;
   logic [PL_W-1:0]    pl;
   logic [ENTRY_W-1:0] exp_w;
   logic [BEAT_W-1:0]  held_d;
   logic               held_l;
   logic               stalled;
   int                 n_beats;

   task automatic chk(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   function automatic logic [BEAT_W-1:0] rep(input logic [Q_BIT-1:0] b);
      logic [BEAT_W-1:0] r;
      for (int i = 0; i < X_PE; i++) r[i*Q_BIT +: Q_BIT] = b;
      return r;
   endfunction

   function automatic logic [UN_W-1:0] fill_un(input logic [NPIX-1:0][OUT_BIT-1:0] v);
      logic [UN_W-1:0] r;
      for (int i = 0; i < X_PE; i++)
         for (int p = 0; p < NPIX; p++) r[(i*NPIX+p)*OUT_BIT +: OUT_BIT] = v[p];
      return r;
   endfunction

   function automatic logic [PL_W-1:0] fill_pl(input logic [OUT_BIT-1:0] v);
      logic [PL_W-1:0] r;
      for (int i = 0; i < X_PE; i++) r[i*OUT_BIT +: OUT_BIT] = v;
      return r;
   endfunction

   // One entry into an idle block with out_ready high: checks latency, every beat, then empty.
   task automatic apply_and_check(input string tag, input logic pool, input logic [4:0] sh,
                                  input logic relu, input logic [UN_W-1:0] u,
                                  input logic [PL_W-1:0] p, input logic [ENTRY_W-1:0] ew,
                                  input int nb);
      wb_if.out_ready = 1'b1;
      @(negedge clk);
      poolop = pool; shift = sh; relu_en = relu;
      result_unpool = u; result_pool = p; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk_bit({tag, " valid at t+1"}, wb_if.out_valid, 1'b0);
      @(negedge clk);
      for (int b = 0; b < nb; b++) begin
         chk_bit($sformatf("%s b%0d valid", tag, b), wb_if.out_valid, 1'b1);
         chk($sformatf("%s b%0d data", tag, b), wb_if.out_data, ew[b*BEAT_W +: BEAT_W]);
         chk_bit($sformatf("%s b%0d last", tag, b), wb_if.out_last, (b == nb - 1));
         @(negedge clk);
      end
      chk_bit({tag, " drained"}, wb_if.out_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; poolop = 1'b0; shift = '0; relu_en = 1'b0;
      result_unpool = '0; result_pool = '0; wb_if.out_ready = 1'b0;

      vecs[0] = '{1'b0, 5'd4,  1'b0, {24'd4096, 24'd40, -24'sd100, 24'd100},
                  {8'd127, 8'd3, -8'sd6, 8'd6}};
      vecs[1] = '{1'b0, 5'd1,  1'b0, {-24'sd3, 24'd3, -24'sd1, 24'd1},
                  {8'hFF, 8'd2, 8'd0, 8'd1}};
      vecs[2] = '{1'b0, 5'd31, 1'b0, {24'h7FFFFF, 24'h800000, 24'h000000, 24'h400000},
                  {8'd1, 8'hFF, 8'd0, 8'd1}};
      vecs[3] = '{1'b0, 5'd0,  1'b1, {24'd127, -24'sd200, 24'd200, -24'sd5},
                  {8'd127, 8'd0, 8'd127, 8'd0}};
      vecs[4] = '{1'b0, 5'd0,  1'b0, {24'd128, 24'd127, -24'sd129, -24'sd128},
                  {8'd127, 8'd127, 8'h80, 8'h80}};
      vecs[5] = '{1'b0, 5'd8,  1'b0, {-24'sd32768, 24'd383, 24'd128, -24'sd1},
                  {8'h80, 8'd1, 8'd1, 8'd0}};
      vecs[6] = '{1'b1, 5'd0,  1'b1, {24'd0, 24'd0, 24'd0, -24'sd5},
                  {8'd0, 8'd0, 8'd0, 8'd0}};
      vecs[7] = '{1'b1, 5'd2,  1'b0, {24'd0, 24'd0, 24'd0, -24'sd7},
                  {8'd0, 8'd0, 8'd0, 8'hFE}};
      vecs[8] = '{1'b0, 5'd24, 1'b1, {24'h3FFFFF, 24'd1, 24'h7FFFFF, -24'sd1},
                  {8'd0, 8'd0, 8'd1, 8'd0}};

      repeat (2) @(negedge clk);
      chk_bit("reset out_valid", wb_if.out_valid, 1'b0);
      chk_bit("reset out_last", wb_if.out_last, 1'b0);
      chk("reset out_data", wb_if.out_data, '0);
      chk_bit("reset almost_full", almost_full, 1'b0);
      chk_bit("reset overflow", overflow, 1'b0);
      rst = 1'b0;

      // Table: every PE carries the same pixels; pooled rows put junk on the unpooled bus.
      for (int k = 0; k < 9; k++) begin
         if (vecs[k].pool) begin
            un    = fill_un({4{24'h7FFFFF}});
            pl    = fill_pl(vecs[k].v[0]);
            exp_w = {{(ENTRY_W-BEAT_W){1'b0}}, rep(vecs[k].e[0])};
            apply_and_check($sformatf("vec%0d", k), 1'b1, vecs[k].sh, vecs[k].relu, un, pl, exp_w, 1);
         end else begin
            un    = fill_un(vecs[k].v);
            pl    = fill_pl(24'h7FFFFF);
            exp_w = {rep(vecs[k].e[3]), rep(vecs[k].e[2]), rep(vecs[k].e[1]), rep(vecs[k].e[0])};
            apply_and_check($sformatf("vec%0d", k), 1'b0, vecs[k].sh, vecs[k].relu, un, pl, exp_w, NPIX);
         end
      end

      // Lane/pixel placement: PE i pixel p = 8i+p, shift 0.
      for (int i = 0; i < X_PE; i++)
         for (int p = 0; p < NPIX; p++) begin
            un[(i*NPIX+p)*OUT_BIT +: OUT_BIT] = 24'(i*8 + p);
            exp_w[(p*X_PE+i)*Q_BIT +: Q_BIT]  = 8'(i*8 + p);
         end
      apply_and_check("map", 1'b0, 5'd0, 1'b0, un, fill_pl(24'd0), exp_w, NPIX);

      // Pooled with ReLU: PE3 = -5, PE5 = 200, others = i.
      exp_w = '0;
      for (int i = 0; i < X_PE; i++) begin
         pl[i*OUT_BIT +: OUT_BIT] = 24'(i);
         exp_w[i*Q_BIT +: Q_BIT]  = 8'(i);
      end
      pl[3*OUT_BIT +: OUT_BIT] = -24'sd5;   exp_w[3*Q_BIT +: Q_BIT] = 8'd0;
      pl[5*OUT_BIT +: OUT_BIT] = 24'd200;   exp_w[5*Q_BIT +: Q_BIT] = 8'd127;
      apply_and_check("pool", 1'b1, 5'd0, 1'b1, fill_un({4{24'h7FFFFF}}), pl, exp_w, 1);

      // Backpressure: five back-to-back unpooled entries, entry k pixel p = 10k+p.
      wb_if.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k >= 1) begin
            chk_bit($sformatf("bp af before entry %0d", k), almost_full, (k - 1 >= 3));
            chk_bit($sformatf("bp ovf before entry %0d", k), overflow, 1'b0);
         end
         poolop = 1'b0; shift = 5'd0; relu_en = 1'b0;
         result_unpool = fill_un({24'(k*10+3), 24'(k*10+2), 24'(k*10+1), 24'(k*10)});
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk_bit("bp ovf before drop", overflow, 1'b0);
      chk_bit("bp af full", almost_full, 1'b1);
      @(negedge clk);
      chk_bit("bp ovf after drop", overflow, 1'b1);

      n_beats = 0; stalled = 1'b0;
      for (int c = 0; c < 80 && n_beats < 16; c++) begin
         @(negedge clk);
         if (stalled) begin
            chk("bp stall data", wb_if.out_data, held_d);
            chk_bit("bp stall last", wb_if.out_last, held_l);
         end
         wb_if.out_ready = c[0];
         stalled = 1'b0;
         if (wb_if.out_valid) begin
            if (wb_if.out_ready) begin
               chk($sformatf("bp beat%0d data", n_beats), wb_if.out_data,
                   rep(8'((n_beats / 4) * 10 + (n_beats % 4))));
               chk_bit($sformatf("bp beat%0d last", n_beats), wb_if.out_last, (n_beats % 4 == 3));
               n_beats++;
            end else begin
               held_d  = wb_if.out_data;
               held_l  = wb_if.out_last;
               stalled = 1'b1;
            end
         end
      end
      chk("bp beat count", BEAT_W'(n_beats), BEAT_W'(16));
      wb_if.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_bit("bp dropped entry absent", wb_if.out_valid, 1'b0);
      chk_bit("bp ovf sticky", overflow, 1'b1);

      // Full FIFO: last-beat pop coincides with the write of a fifth pooled entry.
      rst = 1'b1; wb_if.out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk_bit("sim ovf cleared", overflow, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         poolop = 1'b1; shift = 5'd0; relu_en = 1'b0;
         result_pool = fill_pl((k == 4) ? 24'd50 : 24'(k + 1));
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk_bit("sim af full", almost_full, 1'b1);
      chk("sim head data", wb_if.out_data, rep(8'd1));
      chk_bit("sim head last", wb_if.out_last, 1'b1);
      wb_if.out_ready = 1'b1;
      @(negedge clk);
      chk_bit("sim ovf", overflow, 1'b0);
      chk_bit("sim still full", almost_full, 1'b1);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("sim drain%0d", j), wb_if.out_data, rep((j == 3) ? 8'd50 : 8'(j + 2)));
         @(negedge clk);
      end
      chk_bit("sim drained", wb_if.out_valid, 1'b0);

      // Reset during beat 1, with an in_valid in the reset cycle that must be ignored.
      @(negedge clk);
      poolop = 1'b0; shift = 5'd0; relu_en = 1'b0;
      result_unpool = fill_un({24'd4, 24'd3, 24'd2, 24'd1});
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst beat1 data", wb_if.out_data, rep(8'd2));
      rst = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      chk_bit("rst valid", wb_if.out_valid, 1'b0);
      chk_bit("rst ovf", overflow, 1'b0);
      repeat (2) @(negedge clk);
      chk_bit("rst in_valid ignored", wb_if.out_valid, 1'b0);
      exp_w = {rep(8'd8), rep(8'd7), rep(8'd6), rep(8'd5)};
      apply_and_check("post rst", 1'b0, 5'd0, 1'b0, fill_un({24'd8, 24'd7, 24'd6, 24'd5}),
                      fill_pl(24'd0), exp_w, NPIX);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
